// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM for the MIPS-subset CPU: drives datapath selects,
// memory/register strobes and PC/IR enables, stalling on the memory ack handshake.
module multicycle_control (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] Op_i,
    input  logic       mem_ack_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic [1:0] PCSource_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    localparam logic [3:0] S_IF    = 4'd0;
    localparam logic [3:0] S_ID    = 4'd1;
    localparam logic [3:0] S_MADDR = 4'd2;
    localparam logic [3:0] S_MRD   = 4'd3;
    localparam logic [3:0] S_MWB   = 4'd4;
    localparam logic [3:0] S_MWR   = 4'd5;
    localparam logic [3:0] S_EXR   = 4'd6;
    localparam logic [3:0] S_WBR   = 4'd7;
    localparam logic [3:0] S_BEQ   = 4'd8;
    localparam logic [3:0] S_JMP   = 4'd9;
    localparam logic [3:0] S_EXI   = 4'd10;
    localparam logic [3:0] S_WBI   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b11;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP = 2'b10;

    logic [3:0] state;
    logic [3:0] state_next;

    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = S_IF;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCS_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_ADD;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        case (state)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // IR and PC+4 commit only on the ack cycle so a stalled fetch is harmless
                ir_write  = mem_ack_i;
                pc_write  = mem_ack_i;
                state_next = mem_ack_i ? S_ID : S_IF;
            end
            S_ID: begin
                alu_src_b = SRCB_BR;
                case (Op_i)
                    OP_RTYPE:      state_next = S_EXR;
                    OP_ADDI:       state_next = S_EXI;
                    OP_LW, OP_SW:  state_next = S_MADDR;
                    OP_BEQ:        state_next = S_BEQ;
                    OP_J:          state_next = S_JMP;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_next = S_IF;
                    end
                endcase
            end
            S_MADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = (Op_i == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                mem_read   = 1'b1;
                iord       = 1'b1;
                state_next = mem_ack_i ? S_MWB : S_MRD;
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_next = S_IF;
            end
            S_MWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ack_i;
                state_next = mem_ack_i ? S_IF : S_MWR;
            end
            S_EXR: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNC;
                state_next = S_WBR;
            end
            S_WBR: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_next = S_IF;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_OUT;
                instr_done    = 1'b1;
                state_next    = S_IF;
            end
            S_JMP: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                instr_done = 1'b1;
                state_next = S_IF;
            end
            S_EXI: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = S_WBI;
            end
            S_WBI: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_IF;
            end
            default: begin
                state_next = S_IF;
            end
        endcase
    end

    // Reset masks every output so an aborted instruction never strobes in the reset cycle
    assign PCWrite_o     = pc_write      & ~rst_i;
    assign PCWriteCond_o = pc_write_cond & ~rst_i;
    assign PCSource_o    = rst_i ? '0 : pc_source;
    assign IorD_o        = iord          & ~rst_i;
    assign MemRead_o     = mem_read      & ~rst_i;
    assign MemWrite_o    = mem_write     & ~rst_i;
    assign IRWrite_o     = ir_write      & ~rst_i;
    assign RegDst_o      = reg_dst       & ~rst_i;
    assign MemtoReg_o    = mem_to_reg    & ~rst_i;
    assign RegWrite_o    = reg_write     & ~rst_i;
    assign ALUSrcA_o     = alu_src_a     & ~rst_i;
    assign ALUSrcB_o     = rst_i ? '0 : alu_src_b;
    assign ALUOp_o       = rst_i ? '0 : alu_op;
    assign state_o       = rst_i ? '0 : state;
    assign instr_done_o  = instr_done    & ~rst_i;
    assign illegal_o     = illegal       & ~rst_i;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares state and the full control word against hand-derived values.
module tb_multicycle_control;

    logic       clk_i;
    logic       rst_i;
    logic [5:0] Op_i;
    logic       mem_ack_i;
    logic       PCWrite_o;
    logic       PCWriteCond_o;
    logic [1:0] PCSource_o;
    logic       IorD_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic       RegDst_o;
    logic       MemtoReg_o;
    logic       RegWrite_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [1:0] ALUOp_o;
    logic [3:0] state_o;
    logic       instr_done_o;
    logic       illegal_o;

    int unsigned nvec;
    int unsigned nerr;

    multicycle_control dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .Op_i         (Op_i),
        .mem_ack_i    (mem_ack_i),
        .PCWrite_o    (PCWrite_o),
        .PCWriteCond_o(PCWriteCond_o),
        .PCSource_o   (PCSource_o),
        .IorD_o       (IorD_o),
        .MemRead_o    (MemRead_o),
        .MemWrite_o   (MemWrite_o),
        .IRWrite_o    (IRWrite_o),
        .RegDst_o     (RegDst_o),
        .MemtoReg_o   (MemtoReg_o),
        .RegWrite_o   (RegWrite_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .ALUOp_o      (ALUOp_o),
        .state_o      (state_o),
        .instr_done_o (instr_done_o),
        .illegal_o    (illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Packs named control fields in a fixed order; shares that order with obs_vec()
    function automatic logic [17:0] cw(
        input logic pcw, input logic pcwc, input logic [1:0] pcs, input logic iord,
        input logic mr, input logic mw, input logic irw, input logic rd,
        input logic m2r, input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic done, input logic ill);
        return {pcw, pcwc, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, done, ill};
    endfunction

    function automatic logic [17:0] obs_vec();
        return {PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, MemRead_o, MemWrite_o,
                IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o,
                ALUOp_o, instr_done_o, illegal_o};
    endfunction

    //                               pcw  pcwc pcs   iord mr   mw   irw  rd   m2r  rw   asa  asb   aop   done ill
    localparam logic [17:0] V_ZERO = '0;
    logic [17:0] v_if_ack, v_if_wait, v_id, v_id_ill, v_maddr, v_mrd, v_mwb, v_mwr_wait,
                 v_mwr_ack, v_exr, v_wbr, v_beq, v_jmp, v_exi, v_wbi;

    task automatic step(input string tag, input logic [3:0] exp_state, input logic [17:0] exp_cw);
        logic [17:0] o;
        @(negedge clk_i);
        nvec++;
        assert (state_o === exp_state)
        else begin
            nerr++;
            $error("FAIL %s.state observed=%0d expected=%0d", tag, state_o, exp_state);
        end
        o = obs_vec();
        nvec++;
        assert (o === exp_cw)
        else begin
            nerr++;
            $error("FAIL %s.ctl observed=%b expected=%b", tag, o, exp_cw);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        v_if_ack   = cw(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        v_if_wait  = cw(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        v_id       = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0);
        v_id_ill   = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 1, 1);
        v_maddr    = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0);
        v_mrd      = cw(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        v_mwb      = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0);
        v_mwr_wait = cw(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        v_mwr_ack  = cw(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        v_exr      = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 0, 0);
        v_wbr      = cw(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 1, 0);
        v_beq      = cw(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 0);
        v_jmp      = cw(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        v_exi      = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0);
        v_wbi      = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0);

        rst_i = 1'b1;
        mem_ack_i = 1'b1;
        Op_i = 6'b000000;
        step("rst0", 4'd0, V_ZERO);
        step("rst1", 4'd0, V_ZERO);
        step("rst2", 4'd0, V_ZERO);
        rst_i = 1'b0;

        // R-type, zero-wait: 0,1,6,7
        step("r.if",  4'd0, v_if_ack);
        step("r.id",  4'd1, v_id);
        step("r.exr", 4'd6, v_exr);
        step("r.wbr", 4'd7, v_wbr);

        // lw with two wait cycles in IF and in MRD: 0,0,0,1,2,3,3,3,4
        Op_i = 6'b100011;
        mem_ack_i = 1'b0;
        step("lw.if0", 4'd0, v_if_wait);
        step("lw.if1", 4'd0, v_if_wait);
        mem_ack_i = 1'b1;
        step("lw.if2", 4'd0, v_if_ack);
        mem_ack_i = 1'b0;
        step("lw.id",    4'd1, v_id);
        step("lw.maddr", 4'd2, v_maddr);
        step("lw.mrd0",  4'd3, v_mrd);
        step("lw.mrd1",  4'd3, v_mrd);
        mem_ack_i = 1'b1;
        step("lw.mrd2",  4'd3, v_mrd);
        step("lw.mwb",   4'd4, v_mwb);

        // sw zero-wait: 4 cycles, done on the ack cycle of MWR
        Op_i = 6'b101011;
        step("sw.if",    4'd0, v_if_ack);
        step("sw.id",    4'd1, v_id);
        step("sw.maddr", 4'd2, v_maddr);
        step("sw.mwr",   4'd5, v_mwr_ack);

        // addi
        Op_i = 6'b001000;
        step("addi.if",  4'd0, v_if_ack);
        step("addi.id",  4'd1, v_id);
        step("addi.exi", 4'd10, v_exi);
        step("addi.wbi", 4'd11, v_wbi);

        // beq then j, 3 cycles each
        Op_i = 6'b000100;
        step("beq.if",  4'd0, v_if_ack);
        step("beq.id",  4'd1, v_id);
        step("beq.beq", 4'd8, v_beq);
        Op_i = 6'b000010;
        step("j.if",  4'd0, v_if_ack);
        step("j.id",  4'd1, v_id);
        step("j.jmp", 4'd9, v_jmp);

        // Illegal opcode: 2 cycles, flagged in ID
        Op_i = 6'b111111;
        step("ill.if", 4'd0, v_if_ack);
        step("ill.id", 4'd1, v_id_ill);

        // sw aborted by reset while MWR waits for ack
        Op_i = 6'b101011;
        step("swr.if",    4'd0, v_if_ack);
        step("swr.id",    4'd1, v_id);
        step("swr.maddr", 4'd2, v_maddr);
        mem_ack_i = 1'b0;
        step("swr.mwr",   4'd5, v_mwr_wait);
        rst_i = 1'b1;
        step("swr.rst",   4'd0, V_ZERO);
        rst_i = 1'b0;
        step("swr.if0",   4'd0, v_if_wait);
        mem_ack_i = 1'b1;
        Op_i = 6'b000000;
        step("swr.if1",   4'd0, v_if_ack);
        step("swr.id",    4'd1, v_id);
        step("swr.exr",   4'd6, v_exr);
        step("swr.wbr",   4'd7, v_wbr);
        step("swr.next",  4'd0, v_if_ack);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
